// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer: FSM states,
// redirect-source encoding, the stage-control bundle and the load-use detector.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DM_WAIT = 2'd1,
        ST_HALT    = 2'd2
    } state_e;

    localparam logic REDIR_BRANCH  = 1'b0;
    localparam logic REDIR_SYSCALL = 1'b1;

    // Bit 0 of en/clear is PS1 (IF/ID), bit 3 is PS4 (MEM/WB).
    typedef struct packed {
        logic       pc_en;
        logic       pc_redirect;
        logic       redirect_src;
        logic [3:0] en;
        logic [3:0] clear;
    } stage_ctrl_t;

    // r0 is never a real dependency, so a load targeting it cannot stall ID.
    function automatic logic load_use_hazard(
        input logic       dm_read,
        input logic       w_en,
        input logic [4:0] req_w,
        input logic       uses_rs,
        input logic [4:0] rs,
        input logic       uses_rt,
        input logic [4:0] rt
    );
        logic match_s;
        match_s = (uses_rs && (rs == req_w)) || (uses_rt && (rt == req_w));
        return dm_read && w_en && (req_w != 5'd0) && match_s;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Stage-register and PC enable/clear bundle; the sequencer drives it as master.
interface pipeline_ctrl_if;
    logic pc_en;
    logic pc_redirect;
    logic redirect_src;
    logic ps1_en, ps2_en, ps3_en, ps4_en;
    logic ps1_clear, ps2_clear, ps3_clear, ps4_clear;

    modport master (
        output pc_en, pc_redirect, redirect_src,
        output ps1_en, ps2_en, ps3_en, ps4_en,
        output ps1_clear, ps2_clear, ps3_clear, ps4_clear
    );

    modport slave (
        input pc_en, pc_redirect, redirect_src,
        input ps1_en, ps2_en, ps3_en, ps4_en,
        input ps1_clear, ps2_clear, ps3_clear, ps4_clear
    );
endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count up on inc until saturated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: load-use stalls, mispredict/syscall flushes, data-memory
// wait states with watchdog, and saturating stall/flush counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int DM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_dm_read,
    input  logic             ex_w_en,
    input  logic [4:0]       ex_req_w,
    input  logic             mem_mispredict,
    input  logic             mem_syscall_halt,
    input  logic             dm_busy,
    input  logic             resume,
    pipeline_ctrl_if.master  stg,
    output logic             halted,
    output logic             dm_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int                WAIT_W    = $clog2(DM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DM_TIMEOUT - 1);

    state_e            state_r, next_state_s, run_next_s;
    stage_ctrl_t       run_ctrl_s, ctrl_s, out_s;
    logic              hazard_s;
    logic              run_stall_s, run_flush_s;
    logic              stall_inc_s, flush_inc_s, timeout_set_s, wait_inc_s;
    logic              dm_timeout_r;
    logic [WAIT_W-1:0] wait_cnt_r;

    assign hazard_s = load_use_hazard(ex_dm_read, ex_w_en, ex_req_w,
                                      id_uses_rs, id_rs, id_uses_rt, id_rt);

    // Prioritised RUN decision; DM_WAIT reuses it on its first non-busy cycle.
    always_comb begin
        run_ctrl_s = '{pc_en: 1'b1, pc_redirect: 1'b0, redirect_src: REDIR_BRANCH,
                       en: 4'hF, clear: 4'h0};
        run_next_s  = ST_RUN;
        run_stall_s = 1'b0;
        run_flush_s = 1'b0;
        if (dm_busy) begin
            run_ctrl_s.en    = 4'h0;
            run_ctrl_s.pc_en = 1'b0;
            run_next_s       = ST_DM_WAIT;
            run_stall_s      = 1'b1;
        end else if (mem_syscall_halt) begin
            run_ctrl_s.pc_redirect  = 1'b1;
            run_ctrl_s.redirect_src = REDIR_SYSCALL;
            run_ctrl_s.clear        = 4'b0111;
            run_next_s              = ST_HALT;
        end else if (mem_mispredict) begin
            run_ctrl_s.pc_redirect = 1'b1;
            run_ctrl_s.clear       = 4'b0111;
            run_flush_s            = 1'b1;
        end else if (hazard_s) begin
            run_ctrl_s.pc_en = 1'b0;
            run_ctrl_s.en    = 4'b1110;
            run_ctrl_s.clear = 4'b0010;
            run_stall_s      = 1'b1;
        end else begin
            run_next_s = ST_RUN;
        end
    end

    // FSM next-state and stage controls.
    always_comb begin
        ctrl_s        = '0;
        next_state_s  = state_r;
        stall_inc_s   = 1'b0;
        flush_inc_s   = 1'b0;
        timeout_set_s = 1'b0;
        wait_inc_s    = 1'b0;
        case (state_r)
            ST_RUN: begin
                ctrl_s       = run_ctrl_s;
                next_state_s = run_next_s;
                stall_inc_s  = run_stall_s;
                flush_inc_s  = run_flush_s;
            end
            ST_DM_WAIT: begin
                if (dm_busy) begin
                    stall_inc_s = 1'b1;
                    if (wait_cnt_r == WAIT_LAST) begin
                        next_state_s  = ST_HALT;
                        timeout_set_s = 1'b1;
                    end else begin
                        wait_inc_s = 1'b1;
                    end
                end else begin
                    ctrl_s       = run_ctrl_s;
                    next_state_s = run_next_s;
                    stall_inc_s  = run_stall_s;
                    flush_inc_s  = run_flush_s;
                end
            end
            ST_HALT: begin
                if (resume && !dm_timeout_r) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_HALT;
                end
            end
            default: begin
                next_state_s = ST_RUN;
            end
        endcase
    end

    // Controls are forced inactive while reset is held.
    assign out_s = rst_n ? ctrl_s : '0;

    assign stg.pc_en        = out_s.pc_en;
    assign stg.pc_redirect  = out_s.pc_redirect;
    assign stg.redirect_src = out_s.redirect_src;
    assign stg.ps1_en       = out_s.en[0];
    assign stg.ps2_en       = out_s.en[1];
    assign stg.ps3_en       = out_s.en[2];
    assign stg.ps4_en       = out_s.en[3];
    assign stg.ps1_clear    = out_s.clear[0];
    assign stg.ps2_clear    = out_s.clear[1];
    assign stg.ps3_clear    = out_s.clear[2];
    assign stg.ps4_clear    = out_s.clear[3];

    assign halted     = (state_r == ST_HALT);
    assign dm_timeout = dm_timeout_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Sticky watchdog flag; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dm_timeout_r <= 1'b0;
        end else if (timeout_set_s) begin
            dm_timeout_r <= 1'b1;
        end else begin
            dm_timeout_r <= dm_timeout_r;
        end
    end

    // Wait counter sits at zero outside DM_WAIT, so every entry starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= '0;
        end else if (state_r != ST_DM_WAIT) begin
            wait_cnt_r <= '0;
        end else if (wait_inc_s) begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc_s),
        .cnt   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc_s),
        .cnt   (flush_cnt)
    );

endmodule
